// File: rtl/cosim_pkg.sv
// Shared co-simulation types: register/memory commit records and the
// commit-log collector's beat kinds and drain states.
package cosim_pkg;

  localparam int CommitLogEntries = 16;

  typedef logic [63:0]  reg_key_t;
  typedef logic [127:0] freg_t;
  typedef logic [63:0]  reg_t;

  typedef struct packed {
    reg_key_t key;
    freg_t    value;
  } commit_log_reg_item_t;

  typedef struct packed {
    reg_t       addr;
    reg_t       data;
    logic [7:0] len;
  } commit_log_mem_item_t;

  typedef enum logic [1:0] {
    OUT_NONE = 2'd0,
    OUT_REG  = 2'd1,
    OUT_MEM  = 2'd2
  } out_kind_e;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_REG,
    DRAIN_MEM,
    DRAIN_EMPTY
  } drain_state_e;

endpackage

// File: rtl/cosim_commit_log_bank.sv
// One batch worth of commit records: append-only reg/mem slot arrays,
// their fill counts, and the sequence tag of the batch held here.
module cosim_commit_log_bank
  import cosim_pkg::*;
#(
  parameter int  Entries = CommitLogEntries,
  localparam int CntW    = $clog2(Entries + 1),
  localparam int IdxW    = (Entries > 1) ? $clog2(Entries) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 set_tag_i,
  input  logic [31:0]          tag_i,
  input  logic                 reg_we_i,
  input  commit_log_reg_item_t reg_item_i,
  input  logic                 mem_we_i,
  input  commit_log_mem_item_t mem_item_i,
  input  logic [IdxW-1:0]      rd_idx_i,
  output logic [CntW-1:0]      reg_cnt_o,
  output logic [CntW-1:0]      mem_cnt_o,
  output logic                 reg_full_o,
  output logic                 mem_full_o,
  output logic [31:0]          tag_o,
  output commit_log_reg_item_t reg_rd_o,
  output commit_log_mem_item_t mem_rd_o
);

  commit_log_reg_item_t reg_slots [Entries];
  commit_log_mem_item_t mem_slots [Entries];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_cnt_o <= '0;
      mem_cnt_o <= '0;
      tag_o     <= '0;
    end else begin
      if (clear_i) begin
        reg_cnt_o <= '0;
        mem_cnt_o <= '0;
      end else begin
        if (reg_we_i) reg_cnt_o <= reg_cnt_o + CntW'(1);
        if (mem_we_i) mem_cnt_o <= mem_cnt_o + CntW'(1);
      end
      if (set_tag_i) tag_o <= tag_i;
    end
  end

  // NOTE: slot storage is deliberately not reset; only slots below the count
  // are ever read, so resetting the arrays would cost flops for nothing.
  always_ff @(posedge clk_i) begin
    if (reg_we_i) reg_slots[reg_cnt_o[IdxW-1:0]] <= reg_item_i;
    if (mem_we_i) mem_slots[mem_cnt_o[IdxW-1:0]] <= mem_item_i;
  end

  assign reg_full_o = (reg_cnt_o == CntW'(Entries));
  assign mem_full_o = (mem_cnt_o == CntW'(Entries));
  assign reg_rd_o   = reg_slots[rd_idx_i];
  assign mem_rd_o   = mem_slots[rd_idx_i];

endmodule

// File: rtl/cosim_commit_log_collector.sv
// Collects per-instruction register/memory write records into a staging bank
// and, on retire, hands the batch to a drain bank streamed out one beat per cycle.
module cosim_commit_log_collector
  import cosim_pkg::*;
#(
  parameter int Entries = CommitLogEntries
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rf_we_i,
  input  reg_key_t             rf_key_i,
  input  freg_t                rf_wdata_i,
  input  logic                 mem_we_i,
  input  logic [63:0]          mem_addr_i,
  input  logic [63:0]          mem_wdata_i,
  input  logic [7:0]           mem_len_i,
  input  logic                 retire_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output out_kind_e            out_kind_o,
  output commit_log_reg_item_t out_reg_o,
  output commit_log_mem_item_t out_mem_o,
  output logic                 out_last_o,
  output logic [31:0]          out_seq_o,
  output logic                 overflow_o
);

  localparam int CntW = $clog2(Entries + 1);
  localparam int IdxW = (Entries > 1) ? $clog2(Entries) : 1;

  drain_state_e         state_q, state_d;
  logic [CntW-1:0]      idx_q, idx_d;
  logic                 stage_sel_q;
  logic                 drain_sel;
  logic [31:0]          seq_q;

  logic [CntW-1:0]      reg_cnt  [2];
  logic [CntW-1:0]      mem_cnt  [2];
  logic                 reg_full [2];
  logic                 mem_full [2];
  logic [31:0]          tag      [2];
  commit_log_reg_item_t reg_rd   [2];
  commit_log_mem_item_t mem_rd   [2];

  commit_log_reg_item_t rf_item;
  commit_log_mem_item_t mem_item;
  logic                 retire_acc, rf_append, mem_append, rf_drop, mem_drop;
  logic                 fire;
  logic [CntW-1:0]      d_reg_cnt, d_mem_cnt;

  // The two banks swap roles on every accepted retire instead of copying.
  assign drain_sel  = ~stage_sel_q;
  assign d_reg_cnt  = reg_cnt[drain_sel];
  assign d_mem_cnt  = mem_cnt[drain_sel];

  assign in_ready_o = !(retire_i && (state_q != DRAIN_IDLE));
  assign retire_acc = retire_i && in_ready_o;
  assign rf_append  = rf_we_i  && in_ready_o && !reg_full[stage_sel_q];
  assign mem_append = mem_we_i && in_ready_o && !mem_full[stage_sel_q];
  assign rf_drop    = rf_we_i  && in_ready_o &&  reg_full[stage_sel_q];
  assign mem_drop   = mem_we_i && in_ready_o &&  mem_full[stage_sel_q];
  assign fire       = out_valid_o && out_ready_i;

  assign rf_item  = '{key: rf_key_i, value: rf_wdata_i};
  assign mem_item = '{addr: mem_addr_i, data: mem_wdata_i, len: mem_len_i};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_stage;
    assign is_stage = (stage_sel_q == 1'(b));

    cosim_commit_log_bank #(.Entries(Entries)) u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (retire_acc && !is_stage),
      .set_tag_i  (retire_acc && is_stage),
      .tag_i      (seq_q),
      .reg_we_i   (rf_append && is_stage),
      .reg_item_i (rf_item),
      .mem_we_i   (mem_append && is_stage),
      .mem_item_i (mem_item),
      .rd_idx_i   (idx_q[IdxW-1:0]),
      .reg_cnt_o  (reg_cnt[b]),
      .mem_cnt_o  (mem_cnt[b]),
      .reg_full_o (reg_full[b]),
      .mem_full_o (mem_full[b]),
      .tag_o      (tag[b]),
      .reg_rd_o   (reg_rd[b]),
      .mem_rd_o   (mem_rd[b])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= DRAIN_IDLE;
      idx_q       <= '0;
      stage_sel_q <= 1'b0;
      seq_q       <= '0;
      overflow_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_o <= overflow_o | rf_drop | mem_drop;
      if (retire_acc) begin
        stage_sel_q <= ~stage_sel_q;
        seq_q       <= seq_q + 32'd1;
      end
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      DRAIN_IDLE: begin
        if (retire_acc) begin
          idx_d = '0;
          if ((reg_cnt[stage_sel_q] != '0) || rf_append)       state_d = DRAIN_REG;
          else if ((mem_cnt[stage_sel_q] != '0) || mem_append) state_d = DRAIN_MEM;
          else                                                 state_d = DRAIN_EMPTY;
        end
      end
      DRAIN_REG: begin
        if (fire) begin
          if (idx_q == d_reg_cnt - CntW'(1)) begin
            idx_d   = '0;
            state_d = (d_mem_cnt != '0) ? DRAIN_MEM : DRAIN_IDLE;
          end else begin
            idx_d = idx_q + CntW'(1);
          end
        end
      end
      DRAIN_MEM: begin
        if (fire) begin
          if (idx_q == d_mem_cnt - CntW'(1)) begin
            idx_d   = '0;
            state_d = DRAIN_IDLE;
          end else begin
            idx_d = idx_q + CntW'(1);
          end
        end
      end
      DRAIN_EMPTY: begin
        if (fire) state_d = DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // Data outputs are forced to zero outside a drain so idle/reset reads as 0.
  always_comb begin
    out_valid_o = 1'b0;
    out_kind_o  = OUT_NONE;
    out_reg_o   = '0;
    out_mem_o   = '0;
    out_last_o  = 1'b0;
    out_seq_o   = '0;
    unique case (state_q)
      DRAIN_REG: begin
        out_valid_o = 1'b1;
        out_kind_o  = OUT_REG;
        out_reg_o   = reg_rd[drain_sel];
        out_last_o  = (idx_q == d_reg_cnt - CntW'(1)) && (d_mem_cnt == '0);
        out_seq_o   = tag[drain_sel];
      end
      DRAIN_MEM: begin
        out_valid_o = 1'b1;
        out_kind_o  = OUT_MEM;
        out_mem_o   = mem_rd[drain_sel];
        out_last_o  = (idx_q == d_mem_cnt - CntW'(1));
        out_seq_o   = tag[drain_sel];
      end
      DRAIN_EMPTY: begin
        out_valid_o = 1'b1;
        out_last_o  = 1'b1;
        out_seq_o   = tag[drain_sel];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cosim_commit_log_collector.sv
// Directed bench for cosim_commit_log_collector: single record, empty batches,
// backpressure, overflow, stalled retire and reset mid-drain.
module tb_cosim_commit_log_collector;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         rf_we_i;
  logic [63:0]  rf_key_i;
  logic [127:0] rf_wdata_i;
  logic         mem_we_i;
  logic [63:0]  mem_addr_i;
  logic [63:0]  mem_wdata_i;
  logic [7:0]   mem_len_i;
  logic         retire_i;
  logic         in_ready_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [1:0]   out_kind_o;
  logic [191:0] out_reg_o;
  logic [135:0] out_mem_o;
  logic         out_last_o;
  logic [31:0]  out_seq_o;
  logic         overflow_o;

  int total = 0;
  int bad   = 0;

  // Captured beat from collect().
  bit           got;
  logic [1:0]   c_kind;
  logic [191:0] c_reg;
  logic [135:0] c_mem;
  logic         c_last;
  logic [31:0]  c_seq;

  cosim_commit_log_collector dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rf_we_i     (rf_we_i),
    .rf_key_i    (rf_key_i),
    .rf_wdata_i  (rf_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_len_i   (mem_len_i),
    .retire_i    (retire_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_kind_o  (out_kind_o),
    .out_reg_o   (out_reg_o),
    .out_mem_o   (out_mem_o),
    .out_last_o  (out_last_o),
    .out_seq_o   (out_seq_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    rf_we_i = 0; rf_key_i = '0; rf_wdata_i = '0;
    mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_len_i = '0;
    retire_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    out_ready_i = 0;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
  endtask

  // One input cycle applied at a falling edge, sampled by the following rising edge.
  task automatic cycle(input logic rf_we, input logic [63:0] key, input logic [127:0] val,
                       input logic mem_we, input logic [63:0] addr, input logic [63:0] data,
                       input logic [7:0] len, input logic retire);
    rf_we_i = rf_we; rf_key_i = key; rf_wdata_i = val;
    mem_we_i = mem_we; mem_addr_i = addr; mem_wdata_i = data; mem_len_i = len;
    retire_i = retire;
    @(negedge clk_i);
    clear_inputs();
  endtask

  // Waits (bounded) for one beat, accepts it, and returns its fields.
  task automatic collect();
    got = 0; c_kind = '0; c_reg = '0; c_mem = '0; c_last = 0; c_seq = '0;
    out_ready_i = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid_o) begin
        got = 1; c_kind = out_kind_o; c_reg = out_reg_o; c_mem = out_mem_o;
        c_last = out_last_o; c_seq = out_seq_o;
      end
      @(negedge clk_i);
    end
    out_ready_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    out_ready_i = 0;
    rst_i = 1;
    @(negedge clk_i);
    total++;
    if ({out_valid_o, in_ready_o, out_kind_o, out_last_o, overflow_o, out_seq_o} !==
        {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_ctrl: got v=%b rdy=%b k=%0d l=%b ovf=%b seq=%0d, want 0 1 0 0 0 0",
               out_valid_o, in_ready_o, out_kind_o, out_last_o, overflow_o, out_seq_o);
    end
    total++;
    if ({out_reg_o, out_mem_o} !== '0) begin
      bad++;
      $display("FAIL reset_data: got reg=%h mem=%h, want 0", out_reg_o, out_mem_o);
    end
    rst_i = 0;
    @(negedge clk_i);
  endtask

  task automatic test_single_reg();
    do_reset();
    cycle(1, 64'h50, 128'h1234, 0, '0, '0, '0, 1);
    total++;
    if (out_valid_o !== 1'b1) begin
      bad++; $display("FAIL single_latency: got valid=%b, want 1", out_valid_o);
    end
    collect();
    total++;
    if ({got, c_kind, c_last, c_seq} !== {1'b1, 2'd1, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL single_beat: got got=%b k=%0d l=%b seq=%0d, want 1 1 1 0", got, c_kind, c_last, c_seq);
    end
    total++;
    if (c_reg !== {64'h50, 128'h1234}) begin
      bad++; $display("FAIL single_reg: got %h, want key 50 val 1234", c_reg);
    end
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL single_done: got valid=%b, want 0", out_valid_o);
    end
  endtask

  task automatic test_empty();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      cycle(0, '0, '0, 0, '0, '0, '0, 1);
      collect();
      total++;
      if ({got, c_kind, c_last, c_seq} !== {1'b1, 2'd0, 1'b1, 32'(n)}) begin
        bad++;
        $display("FAIL empty_%0d: got got=%b k=%0d l=%b seq=%0d, want 1 0 1 %0d",
                 n, got, c_kind, c_last, c_seq, n);
      end
    end
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL empty_done: got valid=%b, want 0", out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [191:0] r0, r1;
    logic [135:0] m0;
    r0 = {64'h10, 128'hAAAA};
    r1 = {64'h21, 128'hBBBB};
    m0 = {64'h8000_1000, 64'hDEAD_BEEF, 8'd4};
    do_reset();
    cycle(1, 64'h10, 128'hAAAA, 0, '0, '0, '0, 0);
    cycle(1, 64'h21, 128'hBBBB, 1, 64'h8000_1000, 64'hDEAD_BEEF, 8'd4, 1);
    // Beat 0 held for two stalled cycles, then accepted.
    for (int c = 0; c < 3; c++) begin
      out_ready_i = (c == 2);
      total++;
      if ({out_valid_o, out_kind_o, out_last_o, out_reg_o} !== {1'b1, 2'd1, 1'b0, r0}) begin
        bad++;
        $display("FAIL bp_beat0_c%0d: got v=%b k=%0d l=%b reg=%h, want 1 1 0 %h",
                 c, out_valid_o, out_kind_o, out_last_o, out_reg_o, r0);
      end
      @(negedge clk_i);
    end
    for (int c = 0; c < 2; c++) begin
      out_ready_i = (c == 1);
      total++;
      if ({out_valid_o, out_kind_o, out_last_o, out_reg_o} !== {1'b1, 2'd1, 1'b0, r1}) begin
        bad++;
        $display("FAIL bp_beat1_c%0d: got v=%b k=%0d l=%b reg=%h, want 1 1 0 %h",
                 c, out_valid_o, out_kind_o, out_last_o, out_reg_o, r1);
      end
      @(negedge clk_i);
    end
    for (int c = 0; c < 2; c++) begin
      out_ready_i = (c == 1);
      total++;
      if ({out_valid_o, out_kind_o, out_last_o, out_seq_o, out_mem_o} !==
          {1'b1, 2'd2, 1'b1, 32'd0, m0}) begin
        bad++;
        $display("FAIL bp_beat2_c%0d: got v=%b k=%0d l=%b seq=%0d mem=%h, want 1 2 1 0 %h",
                 c, out_valid_o, out_kind_o, out_last_o, out_seq_o, out_mem_o, m0);
      end
      @(negedge clk_i);
    end
    out_ready_i = 0;
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL bp_done: got valid=%b, want 0", out_valid_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 64'(i) << 4, 128'(i), 0, '0, '0, '0, 0);
      if (i == 15) begin
        total++;
        if (overflow_o !== 1'b0) begin
          bad++; $display("FAIL ovf_at_full: got %b, want 0", overflow_o);
        end
      end
    end
    total++;
    if (overflow_o !== 1'b1) begin
      bad++; $display("FAIL ovf_set: got %b, want 1", overflow_o);
    end
    cycle(0, '0, '0, 0, '0, '0, '0, 1);
    for (int i = 0; i < 16; i++) begin
      collect();
      total++;
      if ({got, c_kind, c_last, c_seq, c_reg} !==
          {1'b1, 2'd1, (i == 15), 32'd0, 64'(i) << 4, 128'(i)}) begin
        bad++;
        $display("FAIL ovf_beat%0d: got got=%b k=%0d l=%b seq=%0d reg=%h, want key %0h val %0h",
                 i, got, c_kind, c_last, c_seq, c_reg, i << 4, i);
      end
    end
    repeat (2) @(negedge clk_i);
    total++;
    if ({out_valid_o, overflow_o} !== 2'b01) begin
      bad++; $display("FAIL ovf_sticky: got v=%b ovf=%b, want 0 1", out_valid_o, overflow_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 64'h50, 128'h1, 0, '0, '0, '0, 1);
    // Second retire offered while the first batch is stalled.
    rf_we_i = 1; rf_key_i = 64'h60; rf_wdata_i = 128'h2; retire_i = 1;
    #1;
    total++;
    if (in_ready_o !== 1'b0) begin
      bad++; $display("FAIL b2b_stall: got in_ready=%b, want 0", in_ready_o);
    end
    total++;
    if ({out_valid_o, out_kind_o, out_last_o, out_seq_o, out_reg_o} !==
        {1'b1, 2'd1, 1'b1, 32'd0, 64'h50, 128'h1}) begin
      bad++;
      $display("FAIL b2b_first: got v=%b k=%0d l=%b seq=%0d reg=%h, want 1 1 1 0 key 50 val 1",
               out_valid_o, out_kind_o, out_last_o, out_seq_o, out_reg_o);
    end
    @(negedge clk_i);
    out_ready_i = 1;
    @(negedge clk_i);
    out_ready_i = 0;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++; $display("FAIL b2b_resume: got in_ready=%b, want 1", in_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    collect();
    total++;
    if ({got, c_kind, c_last, c_seq, c_reg} !== {1'b1, 2'd1, 1'b1, 32'd1, 64'h60, 128'h2}) begin
      bad++;
      $display("FAIL b2b_second: got got=%b k=%0d l=%b seq=%0d reg=%h, want 1 1 1 1 key 60 val 2",
               got, c_kind, c_last, c_seq, c_reg);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 64'(i + 1) << 4, 128'(i), 0, '0, '0, '0, (i == 2));
    cycle(0, '0, '0, 1, 64'h40, 64'h5, 8'd1, 1);
    collect();
    total++;
    if ({got, c_kind, c_seq} !== {1'b1, 2'd1, 32'd0}) begin
      bad++; $display("FAIL mid_first: got got=%b k=%0d seq=%0d, want 1 1 0", got, c_kind, c_seq);
    end
    rst_i = 1;
    #1;
    total++;
    if ({out_valid_o, in_ready_o, out_kind_o, out_last_o, overflow_o} !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset: got v=%b rdy=%b k=%0d l=%b ovf=%b, want 0 1 0 0 0",
               out_valid_o, in_ready_o, out_kind_o, out_last_o, overflow_o);
    end
    @(negedge clk_i);
    rst_i = 0;
    out_ready_i = 1;
    repeat (3) @(negedge clk_i);
    out_ready_i = 0;
    total++;
    if (out_valid_o !== 1'b0) begin
      bad++; $display("FAIL mid_quiet: got valid=%b, want 0", out_valid_o);
    end
    cycle(0, '0, '0, 0, '0, '0, '0, 1);
    collect();
    total++;
    if ({got, c_kind, c_last, c_seq} !== {1'b1, 2'd0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL mid_restart: got got=%b k=%0d l=%b seq=%0d, want 1 0 1 0", got, c_kind, c_last, c_seq);
    end
  endtask

  initial begin
    test_reset();
    test_single_reg();
    test_empty();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cosim_commit_log_collector.md
COSIM_COMMIT_LOG_COLLECTOR -- requirements
Module: cosim_commit_log_collector

Interface
REQ-001 SHALL have parameter Entries, default CommitLogEntries (16), max register-write and memory-write records per retired instruction.
REQ-002 SHALL have clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have rf_we_i  input  1  DUT register-write event valid.
REQ-005 SHALL have rf_key_i  input  64 (reg_key_t)  written register key: type in low 4 bits, id above.
REQ-006 SHALL have rf_wdata_i  input  128 (freg_t)  written value, zero-extended by DUT.
REQ-007 SHALL have mem_we_i  input  1  DUT memory-write event valid.
REQ-008 SHALL have mem_addr_i / mem_wdata_i / mem_len_i  input  64/64/8  write address, data, byte length.
REQ-009 SHALL have retire_i  input  1  instruction boundary; closes the current batch.
REQ-010 SHALL have in_ready_o  output  1  events and retire accepted only when high.
REQ-011 SHALL have out_valid_o / out_ready_i  output/input  1/1  drain handshake.
REQ-012 SHALL have out_kind_o  output  2  beat kind: 0 NONE, 1 REG, 2 MEM.
REQ-013 SHALL have out_reg_o  output  192 (commit_log_reg_item_t)  register record, valid when kind=REG.
REQ-014 SHALL have out_mem_o  output  136 (commit_log_mem_item_t)  memory record, valid when kind=MEM.
REQ-015 SHALL have out_last_o / out_seq_o  output  1/32  final beat of batch; batch sequence number.
REQ-016 SHALL have overflow_o  output  1  sticky: records were dropped.

Function
REQ-017 SHALL hold two banks, staging and drain; each has Entries reg slots, Entries mem slots, counts of width $clog2(Entries+1), and a seq tag.
REQ-018 SHALL append an accepted rf_we_i or mem_we_i record to staging at index = current count, in arrival order; both kinds in one cycle SHALL both be stored.
REQ-019 SHALL drop a record arriving when its staging count equals Entries, and set overflow_o on the next edge.
REQ-020 SHALL include events in the retire_i cycle in the retiring batch.
REQ-021 SHALL, on accepted retire_i, move staging to drain, clear staging counts, tag the batch with seq counter, and increment seq (wraps 2^32-1 -> 0).
REQ-022 SHALL drive in_ready_o = 0 only when retire_i=1 and drain bank is not idle; in that cycle no event or retire is accepted; no output bypass.
REQ-023 SHALL run drain FSM IDLE -> REG -> MEM -> IDLE; the REG state is skipped if reg count is 0, and MEM is skipped if mem count is 0.
REQ-024 SHALL emit exactly one NONE beat with out_last_o=1 for a batch with zero records (state EMPTY).
REQ-025 SHALL advance one record per cycle with out_valid_o && out_ready_i; out fields SHALL be stable while valid && !ready.
REQ-026 SHALL assert out_last_o on the final beat; the drain bank becomes idle on the edge that accepts it.
REQ-027 SHALL drive out_seq_o with the draining batch tag on every beat; latency from retire edge to first out_valid_o = 1 cycle.

Reset
REQ-028 SHALL on rst_i clear counts, seq, and overflow_o, and set FSM to IDLE; out_valid_o=0, in_ready_o=1, out_kind_o=0, out_last_o=0, data outputs 0.
REQ-029 SHALL abandon a batch mid-drain or mid-staging on reset with no further beats.

Structure
REQ-030 SHALL take reg_key_t, freg_t, reg_t, commit_log_reg_item_t, commit_log_mem_item_t, and CommitLogEntries from cosim_pkg; SHALL add the out-kind enum (NONE/REG/MEM) there.
REQ-031 SHALL put the per-bank record storage in one sub-module, cosim_commit_log_bank, instantiated twice.

Verification
REQ-032 SHALL cover: one reg write key 0x0000_0000_0000_0050 (x5), value 0x1234 + retire -> one REG beat, last=1, seq=0.
REQ-033 SHALL cover: retire with no writes, three times -> three NONE beats, last=1, seq 0,1,2.
REQ-034 SHALL cover: two reg + one mem write (addr 0x8000_1000, len 4) same batch, out_ready_i toggled -> REG, REG, MEM(last), fields stable under backpressure.
REQ-035 SHALL cover: 17 reg writes then retire -> 16 REG beats, overflow_o=1 and sticky.
REQ-036 SHALL cover: second retire while first batch is stalled (out_ready_i=0) -> in_ready_o=0 that cycle, batch accepted after drain ends, seq ordered.
REQ-037 SHALL cover: rst_i asserted mid-drain -> out_valid_o=0 immediately, seq restarts at 0.
